// File: rtl/led_pwm_ctrl.sv
// Four-channel LED driver with a two-state request/response register port.
// Direct mode drives DIRECT[3:0]; PWM mode compares an 8-bit counter against shadowed duties.
module led_pwm_ctrl #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  led
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  localparam logic [15:0] PrescMax = 16'(PRESCALE - 1);

  state_e      state_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  ctrl_q;
  logic [3:0]  direct_q;
  logic [7:0]  shadow_q [4];
  logic [7:0]  active_q [4];
  logic [15:0] presc_q, presc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  led_q, led_d;

  logic        accept;
  logic        run;
  logic        tick;
  logic        wrap;
  logic [31:0] rdata;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign run       = ctrl_q[0] & ctrl_q[1];
  assign tick      = (presc_q == PrescMax);
  assign wrap      = run & tick & (cnt_q == 8'hFF);

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign led       = led_q;

  always_comb begin
    rdata = '0;
    case (req_addr)
      4'd0: rdata[1:0] = ctrl_q;
      4'd1: rdata[3:0] = direct_q;
      4'd2: rdata[7:0] = shadow_q[0];
      4'd3: rdata[7:0] = shadow_q[1];
      4'd4: rdata[7:0] = shadow_q[2];
      4'd5: rdata[7:0] = shadow_q[3];
      4'd6: rdata[8:0] = {run, cnt_q};
      default: rdata = '0;
    endcase
  end

  // Counters only advance in PWM mode; leaving it parks both at zero.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (!run) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = cnt_q + 8'd1;
    end else begin
      presc_d = presc_q + 16'd1;
    end
  end

  always_comb begin
    led_d = '0;
    if (ctrl_q[0]) begin
      if (!ctrl_q[1]) begin
        led_d = direct_q;
      end else begin
        for (int i = 0; i < 4; i++) begin
          led_d[i] = (cnt_q < active_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= req_we ? '0 : rdata;
          end
        end
        StResp: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= '0;
      direct_q <= '0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (accept && req_we) begin
      case (req_addr)
        4'd0: ctrl_q      <= req_wdata[1:0];
        4'd1: direct_q    <= req_wdata[3:0];
        4'd2: shadow_q[0] <= req_wdata[7:0];
        4'd3: shadow_q[1] <= req_wdata[7:0];
        4'd4: shadow_q[2] <= req_wdata[7:0];
        4'd5: shadow_q[3] <= req_wdata[7:0];
        default: ;
      endcase
    end
  end

  // Active duties load from the pre-write shadow, so a DUTY write that lands on
  // the wrap edge only takes effect one period later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        active_q[i] <= '0;
      end
    end else if (!run || wrap) begin
      for (int i = 0; i < 4; i++) begin
        active_q[i] <= shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

endmodule
